// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types, frame constants and parity helper for the
//                UART transmit engine.
//  Contents    : state_t     - transmit FSM state (IDLE, SHIFT)
//                FRAME_BITS  - bit times per frame, start bit included
//                START_IDX   - wire position of the start bit
//                LAST_IDX    - wire position of the final stop bit
//                par_calc()  - parity over the used data bits
//  Revision    : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int FRAME_BITS = 11;
    localparam int START_IDX  = 0;
    localparam int LAST_IDX   = 10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Parity over the data bits that actually go on the wire. In 7-bit mode
    // bit 7 is masked off so it can never influence the parity bit.
    // ohel=1 gives odd parity, ohel=0 gives even parity.
    function automatic logic par_calc(
        input logic [7:0] data,
        input logic       eight,
        input logic       ohel
    );
        logic [7:0] w_used;
        w_used = eight ? data : {1'b0, data[6:0]};
        return (^w_used) ^ ohel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_bit_time_counter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_bit_time_counter
//  Description : Bit time counter for the transmit path. Counts
//                0..k_eff-1 while running, k_eff = max(k,1), and pulses btu
//                on the last count of every bit time. Held at 0 when idle.
//  Ports       : i_clk    - system clock, rising edge
//                i_rst_n  - asynchronous active-low reset
//                i_run    - count enable; count forced to 0 when low
//                i_k      - clocks per bit time (0 behaves as 1)
//                o_count  - current count within the bit time
//                o_btu    - one-cycle end-of-bit-time pulse
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_bit_time_counter #(
    parameter int CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_k,
    output logic [CNT_W-1:0] o_count,
    output logic             o_btu
);

    localparam logic [CNT_W-1:0] c_one = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_last;
    logic             w_btu;

    // Terminal count is k-1, except k=0 which is treated as k=1 so the
    // counter never has to wrap through the full range.
    assign w_last = (i_k == '0) ? '0 : (i_k - c_one);
    assign w_btu  = i_run && (r_count == w_last);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (!i_run || w_btu) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_one;
        end
    end

    assign o_count = r_count;
    assign o_btu   = w_btu;

endmodule
`default_nettype wire

// File: rtl/uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_engine
//  Description : UART transmit engine. Accepts a byte on a load strobe and
//                sends it LSB-first as a fixed 11-bit-time frame:
//                start, 7/8 data, optional parity, stop fill.
//  Ports       : i_clk    - system clock, rising edge
//                i_rst_n  - asynchronous active-low reset
//                i_data   - byte to send (bit 7 ignored in 7-bit mode)
//                i_load   - one-cycle transmit request
//                i_k      - clocks per bit time, sampled at load
//                i_eight  - 1: 8 data bits, 0: 7 data bits
//                i_pen    - parity enable
//                i_ohel   - 1: odd parity, 0: even parity
//                o_tx     - serial line, idle high, registered
//                o_tx_rdy - idle and able to accept a load
//                o_btu    - end-of-bit-time pulse
//  Revision    : 1.0  initial release
// ============================================================================
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [7:0]       i_data,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_k,
    input  logic             i_eight,
    input  logic             i_pen,
    input  logic             i_ohel,
    output logic             o_tx,
    output logic             o_tx_rdy,
    output logic             o_btu
);

    localparam logic [3:0] c_last_idx = 4'(LAST_IDX);

    state_t                  r_state;
    state_t                  w_state_next;
    logic                    w_accept;
    logic [CNT_W-1:0]        r_k;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [3:0]              r_bit_cnt;
    logic                    r_tx;
    logic [FRAME_BITS-1:0]   w_frame;
    logic                    w_par_bit;
    logic                    w_btu;
    logic                    w_run;
    logic                    w_last_bit;
    logic [CNT_W-1:0]        w_count;

    // ------------------------------------------------------------------
    // Frame build: done entirely in the load cycle, so later changes to
    // data/eight/pen/ohel cannot reach the frame in flight.
    // ------------------------------------------------------------------
    always_comb begin
        w_par_bit = i_pen ? par_calc(i_data, i_eight, i_ohel) : 1'b1;
        if (i_eight) begin
            w_frame = {1'b1, w_par_bit, i_data, 1'b0};
        end else begin
            w_frame = {2'b11, w_par_bit, i_data[6:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------
    // Bit time counter
    // ------------------------------------------------------------------
    assign w_run = (r_state == SHIFT);

    uart_tx_bit_time_counter #(
        .CNT_W (CNT_W)
    ) u_btc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_run   (w_run),
        .i_k     (r_k),
        .o_count (w_count),
        .o_btu   (w_btu)
    );

    assign w_last_bit = (r_bit_cnt == c_last_idx);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_load) begin
                    w_state_next = SHIFT;
                    w_accept     = 1'b1;
                end
            end
            SHIFT: begin
                // A load here is simply dropped: no queueing.
                if (w_btu && w_last_bit) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shift register, bit counter, line driver.
    // r_tx holds the bit currently on the wire; r_shift[1] is the next one.
    // Shifting fills with 1 so the line returns to idle after the frame.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_k       <= '0;
            r_shift   <= '1;
            r_bit_cnt <= '0;
            r_tx      <= 1'b1;
        end else if (w_accept) begin
            r_k       <= i_k;
            r_shift   <= w_frame;
            r_bit_cnt <= '0;
            r_tx      <= w_frame[START_IDX];
        end else if (w_btu) begin
            r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
            r_tx      <= r_shift[1];
            r_bit_cnt <= w_last_bit ? 4'd0 : (r_bit_cnt + 4'd1);
        end
    end

    assign o_tx     = r_tx;
    assign o_tx_rdy = (r_state == IDLE);
    assign o_btu    = w_btu;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_engine
//  Description : Self-checking bench for uart_tx_engine. Expected line
//                waveforms are derived from the frame format: the frame bits
//                are assembled from the byte and flags, then each bit is
//                expected on the line for max(k,1) cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_engine;

    localparam int CNT_W = 20;

    logic             clk;
    logic             rst_n;
    logic [7:0]       data;
    logic             load;
    logic [CNT_W-1:0] k;
    logic             eight;
    logic             pen;
    logic             ohel;
    logic             tx;
    logic             tx_rdy;
    logic             btu;

    int total = 0;
    int bad   = 0;

    uart_tx_engine #(
        .CNT_W (CNT_W)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_data   (data),
        .i_load   (load),
        .i_k      (k),
        .i_eight  (eight),
        .i_pen    (pen),
        .i_ohel   (ohel),
        .o_tx     (tx),
        .o_tx_rdy (tx_rdy),
        .o_btu    (btu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one frame starting in the current cycle (caller stands at
    // posedge+1 with tx_rdy expected high). busy_at: cycle index within the
    // frame where a stray load with 0xFF is pulsed. abort_at: cycle index
    // where reset is asserted mid-frame (frame is then abandoned).
    task automatic send_frame(input logic [7:0] d, input int kk, input logic e,
                              input logic p, input logic o,
                              input int busy_at, input int abort_at);
        logic [10:0] fb;
        logic [7:0]  used;
        logic        par;
        int          keff;
        int          idx;
        keff = (kk == 0) ? 1 : kk;
        used = e ? d : (d & 8'h7F);
        par  = (($countones(used) % 2) == 1) ^ o;
        fb   = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < (e ? 8 : 7); i++) fb[1 + i] = d[i];
        fb[e ? 9 : 8] = p ? par : 1'b1;

        check("pre_load_rdy", tx_rdy, 1);
        data  = d;
        k     = CNT_W'(kk);
        eight = e;
        pen   = p;
        ohel  = o;
        load  = 1'b1;
        tick();
        load  = 1'b0;
        // Inputs after the load cycle must not matter.
        data  = 8'($urandom);
        k     = CNT_W'($urandom);
        eight = 1'($urandom);
        pen   = 1'($urandom);
        ohel  = 1'($urandom);

        idx = 0;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < keff; c++) begin
                check($sformatf("tx b%0d c%0d", i, c), tx, fb[i]);
                check($sformatf("rdy b%0d c%0d", i, c), tx_rdy, 0);
                check($sformatf("btu b%0d c%0d", i, c), btu, (c == keff - 1));
                if (idx == abort_at) begin
                    #2;
                    rst_n = 1'b0;
                    #1;
                    check("rst_async_tx", tx, 1);
                    check("rst_async_rdy", tx_rdy, 1);
                    check("rst_async_btu", btu, 0);
                    tick();
                    rst_n = 1'b1;
                    tick();
                    check("rst_after_tx", tx, 1);
                    check("rst_after_rdy", tx_rdy, 1);
                    return;
                end
                load = (idx == busy_at);
                if (idx == busy_at) data = 8'hFF;
                tick();
                idx++;
            end
        end
        load = 1'b0;
        check("end_tx", tx, 1);
        check("end_rdy", tx_rdy, 1);
        check("end_btu", btu, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        data  = '0;
        k     = '0;
        eight = 1'b0;
        pen   = 1'b0;
        ohel  = 1'b0;

        #100;
        check("reset_tx", tx, 1);
        check("reset_rdy", tx_rdy, 1);
        check("reset_btu", btu, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 500; i++) begin
            check("idle_tx", tx, 1);
            check("idle_btu", btu, 0);
            tick();
        end

        // 8N1, long bit time
        send_frame(8'h55, 109, 1'b1, 1'b0, 1'b0, -1, -1);
        tick();
        // 8 data, odd parity
        send_frame(8'hA5, 10, 1'b1, 1'b1, 1'b1, -1, -1);
        tick();
        // 7 data, even parity, bit 7 ignored
        send_frame(8'hC1, 10, 1'b0, 1'b1, 1'b0, -1, -1);
        tick();
        // busy load ignored, then back-to-back load on the ready cycle
        send_frame(8'h0F, 7, 1'b1, 1'b0, 1'b0, 20, -1);
        send_frame(8'h33, 7, 1'b1, 1'b0, 1'b0, -1, -1);
        tick();
        // reset during bit 4, then a clean frame
        send_frame(8'h96, 5, 1'b1, 1'b1, 1'b0, -1, 22);
        send_frame(8'h96, 5, 1'b1, 1'b1, 1'b0, -1, -1);
        // k=0 behaves as k=1
        send_frame(8'h6B, 0, 1'b1, 1'b1, 1'b1, -1, -1);

        // randomized frames, some back-to-back, some with idle gaps
        for (int n = 0; n < 12; n++) begin
            int gap;
            send_frame(8'($urandom), int'($urandom_range(0, 6)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), -1, -1);
            gap = int'($urandom_range(0, 3));
            for (int g = 0; g < gap; g++) begin
                tick();
                check("gap_tx", tx, 1);
                check("gap_rdy", tx_rdy, 1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_engine.md
Name: uart_tx_engine

Overview:
UART transmit engine; the transmit-side counterpart of the receive bit time counter path. Accepts a parallel byte on a load strobe and serialises it LSB-first onto tx as one fixed-length 11-bit-time frame. Frame length is start + 7/8 data + optional parity + stop fill. Bit period is set at run time by the baud count k. Sits between the CPU/UART register interface (data, load, tx_rdy) and the serial TX pin.

Parameters:
CNT_W, 20, width of baud count k and the internal bit time counter
FRAME_BITS, 11, bit times per frame including start bit; fixed, not user-tuned

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
data  input  8  byte to transmit; bit 7 ignored when eight=0
load  input  1  one-cycle strobe; request to transmit data
k  input  CNT_W  clocks per bit time; sampled at load
eight  input  1  1 = 8 data bits, 0 = 7 data bits; sampled at load
pen  input  1  parity enable; sampled at load
ohel  input  1  1 = odd parity, 0 = even parity; sampled at load
tx  output  1  serial line, idle high
tx_rdy  output  1  1 = idle and able to accept load
btu  output  1  one-cycle pulse at end of each bit time (debug/status)

Behaviour:
- Reset (reset=0, async): tx=1, tx_rdy=1, btu=0, state=IDLE, counters=0, shift register=all 1s.
- FSM states: IDLE, SHIFT.
- IDLE -> SHIFT on load=1 while tx_rdy=1 (cycle T). During T, latch k, eight, pen, ohel and data, and build frame[10:0].
- Frame layout (bit 0 first on wire), with parity computed over the used data bits (par = ^bits XOR ohel):
  - b0 = 0 (start).
  - eight=1: b1..b8 = d0..d7, b9 = pen ? par : 1, b10 = 1.
  - eight=0: b1..b7 = d0..d6, b8 = pen ? par : 1, b9 = 1, b10 = 1.
- Outputs at T+1: tx=0 (start bit) and tx_rdy=0. tx is driven from a register, never combinational.
- Bit time counter:
  - Counts 0..k_eff-1, where k_eff = max(k,1); k=0 behaves as k=1.
  - btu=1 on the cycle count==k_eff-1, then count wraps to 0.
  - Count is held at 0 in IDLE.
- Shift register:
  - On each btu, shift right with 1 fill; tx takes the next bit at the following clock.
  - The bit counter increments on each btu.
- SHIFT -> IDLE on the btu where the bit counter reaches 10 (the 11th bit time ends).
  - tx_rdy=1 and tx=1 at T+1+11*k_eff.
  - Each bit is held exactly k_eff cycles.
- Boundary conditions:
  - load while tx_rdy=0: ignored, no queuing, no effect on the current frame.
  - load on the same cycle tx_rdy is 1 again: accepted; the next start bit immediately follows the last stop bit, with no extra idle cycle.
  - Changes to k/eight/pen/ohel/data after T do not affect the current frame.
  - Reset mid-frame: immediate return to reset values; tx=1 within the same cycle (async).
  - Counter width: k up to 2^CNT_W-1; there is no overflow path.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE, SHIFT).
  - FRAME_BITS=11.
  - Frame-bit index constants START_IDX=0 and LAST_IDX=10.
  - Parity function par_calc(data, eight, ohel).
- One sub-module: uart_tx_bit_time_counter.
  - Ports: clk, reset, run, k, count, btu.
  - Mirrors the receive-side bit time counter but has no half-bit mode.
- Frame build, shift register, bit counter and FSM live in uart_tx_engine.

Test Plan:
- Reset: assert reset=0 for 100 ns with load=0 -> tx=1, tx_rdy=1, btu=0; hold idle 500 cycles -> tx stays 1.
- 8N1: k=109, eight=1, pen=0, data=0x55, single load -> tx sequence 0,1,0,1,0,1,0,1,0,1,1, each bit 109 cycles; tx_rdy rises at T+1+1199; 11 btu pulses total.
- 8 odd: k=10, eight=1, pen=1, ohel=1, data=0xA5 -> bits 0,1,0,1,0,0,1,0,1,1,1 (parity=1).
- 7 even: k=10, eight=0, pen=1, ohel=0, data=0xC1 -> bits 0,1,0,0,0,0,0,1,0,1,1 (parity=0; data bit 7 ignored).
- Busy and back-to-back: load 0x0F; re-pulse load with 0xFF mid-frame -> ignored, frame unchanged. Load 0x33 on the cycle tx_rdy=1 -> start bit begins exactly when the prior stop bit ends.
- Reset mid-frame and k=0: reset=0 during bit 4 -> tx=1 and tx_rdy=1 immediately, and the next load sends a clean frame. k=0 frame -> each bit lasts 1 cycle, frame completes in 11 cycles.
